// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package used by the brq host adapters.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic [15:0] TlAUserDefault = 16'h0000;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/brq_tlul_host_arb.sv
// Multi-channel TL-UL host adapter: round-robin arbitration of NumCh core ports onto one
// TL-UL host, per-channel source IDs and in-order response delivery from a slot table.
// Optional: define BRQ_TLUL_RSP_BYPASS_EN to forward a head-slot D beat in the same cycle.
module brq_tlul_host_arb
  import tlul_pkg::*;
#(
  parameter int unsigned NumCh   = 2,
  parameter int unsigned MaxReqs = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumCh-1:0]       req_i,
  output logic [NumCh-1:0]       gnt_o,
  input  logic [NumCh-1:0][31:0] addr_i,
  input  logic [NumCh-1:0]       we_i,
  input  logic [NumCh-1:0][31:0] wdata_i,
  input  logic [NumCh-1:0][3:0]  be_i,
  output logic [NumCh-1:0]       valid_o,
  output logic [NumCh-1:0][31:0] rdata_o,
  output logic [NumCh-1:0]       err_o,
  output tl_h2d_t                tl_h_o,
  input  tl_d2h_t                tl_h_i
);

  localparam int unsigned ChW   = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned SlotW = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
  localparam int unsigned CntW  = $clog2(MaxReqs + 1);

  logic [ChW-1:0]                      rr_q, rr_d;
  logic                                lock_q, lock_d;
  logic [ChW-1:0]                      lock_ch_q, lock_ch_d;
  logic [NumCh-1:0][SlotW-1:0]         iptr_q, iptr_d, rptr_q, rptr_d;
  logic [NumCh-1:0][CntW-1:0]          cnt_q, cnt_d;
  logic [NumCh-1:0][MaxReqs-1:0]       pend_q, pend_d, done_q, done_d, serr_q, serr_d;
  logic [NumCh-1:0][MaxReqs-1:0][31:0] sdata_q, sdata_d;

  logic [NumCh-1:0] elig;
  logic             win_vld;
  logic [ChW-1:0]   win;
  logic             hs;

  logic [7:0]       d_ch_full;
  logic [ChW-1:0]   d_ch;
  logic [SlotW-1:0] d_slot;
  logic             d_hit_vld;
  logic [NumCh-1:0] byp;

  logic unused_tl;
  assign unused_tl = ^{tl_h_i.d_opcode, tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink,
                       tl_h_i.d_user};

  // D beat decode; out-of-range channel or slot is treated as unexpected.
  assign d_ch_full = tl_h_i.d_source >> SlotW;
  assign d_ch      = d_ch_full[ChW-1:0];
  assign d_slot    = tl_h_i.d_source[SlotW-1:0];
  assign d_hit_vld = tl_h_i.d_valid && (32'(d_ch_full) < NumCh) && (32'(d_slot) < MaxReqs);

  // Winner selection: a stalled winner stays locked, otherwise first eligible from rr.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win_vld = 1'b0;
    win     = '0;
    for (int unsigned c = 0; c < NumCh; c++) begin
      elig[c] = req_i[c] && (32'(cnt_q[c]) < MaxReqs);
    end
    if (lock_q) begin
      win_vld = 1'b1;
      win     = lock_ch_q;
    end else begin
      for (int unsigned i = 0; i < NumCh; i++) begin
        idx = (32'(rr_q) + i) % NumCh;
        if (!win_vld && elig[idx]) begin
          win_vld = 1'b1;
          win     = ChW'(idx);
        end
      end
    end
    hs    = win_vld && tl_h_i.a_ready;
    gnt_o = '0;
    if (hs) gnt_o[win] = 1'b1;
  end

  // A channel fields driven from the winning channel.
  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = win_vld;
    tl_h_o.a_opcode  = !we_i[win] ? Get : ((be_i[win] == 4'hF) ? PutFullData : PutPartialData);
    tl_h_o.a_param   = 3'd0;
    tl_h_o.a_size    = 2'd2;
    tl_h_o.a_source  = 8'({win, iptr_q[win]});
    tl_h_o.a_address = {addr_i[win][31:2], 2'b00};
    tl_h_o.a_mask    = be_i[win];
    tl_h_o.a_data    = wdata_i[win];
    tl_h_o.a_user    = TlAUserDefault;
    tl_h_o.d_ready   = 1'b1;
  end

  // Same-cycle forwarding of a D beat that lands on a not-yet-done head slot.
  always_comb begin
    byp = '0;
`ifdef BRQ_TLUL_RSP_BYPASS_EN
    for (int unsigned c = 0; c < NumCh; c++) begin
      byp[c] = d_hit_vld && (d_ch == ChW'(c)) && (d_slot == rptr_q[c]) &&
               pend_q[c][d_slot] && !done_q[c][d_slot];
    end
`endif
  end

  // Response outputs: head slot when done, or the forwarded beat.
  always_comb begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      valid_o[c] = done_q[c][rptr_q[c]];
      rdata_o[c] = valid_o[c] ? sdata_q[c][rptr_q[c]] : 32'h0;
      err_o[c]   = valid_o[c] && serr_q[c][rptr_q[c]];
      if (byp[c]) begin
        valid_o[c] = 1'b1;
        rdata_o[c] = tl_h_i.d_data;
        err_o[c]   = tl_h_i.d_error;
      end
    end
  end

  // Slot table, pointers, counts, rr and lock next state.
  always_comb begin
    logic ret;
    logic iss;
    ret       = 1'b0;
    iss       = 1'b0;
    rr_d      = rr_q;
    lock_d    = win_vld && !tl_h_i.a_ready;
    lock_ch_d = win;
    iptr_d    = iptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    done_d    = done_q;
    serr_d    = serr_q;
    sdata_d   = sdata_q;
    if (hs) rr_d = (32'(win) == NumCh - 1) ? '0 : win + 1'b1;
    for (int unsigned c = 0; c < NumCh; c++) begin
      ret = done_q[c][rptr_q[c]] || byp[c];
      iss = hs && (win == ChW'(c));
      if (ret) begin
        pend_d[c][rptr_q[c]] = 1'b0;
        done_d[c][rptr_q[c]] = 1'b0;
        rptr_d[c] = (32'(rptr_q[c]) == MaxReqs - 1) ? '0 : rptr_q[c] + 1'b1;
      end
      // Duplicate beats for an already-done slot are ignored.
      if (d_hit_vld && (d_ch == ChW'(c)) && pend_q[c][d_slot] && !done_q[c][d_slot] &&
          !byp[c]) begin
        done_d[c][d_slot]  = 1'b1;
        sdata_d[c][d_slot] = tl_h_i.d_data;
        serr_d[c][d_slot]  = tl_h_i.d_error;
      end
      if (iss) begin
        pend_d[c][iptr_q[c]] = 1'b1;
        iptr_d[c] = (32'(iptr_q[c]) == MaxReqs - 1) ? '0 : iptr_q[c] + 1'b1;
      end
      if (iss && !ret) cnt_d[c] = cnt_q[c] + 1'b1;
      else if (!iss && ret) cnt_d[c] = cnt_q[c] - 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      iptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      done_q    <= '0;
      serr_q    <= '0;
      sdata_q   <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      iptr_q    <= iptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      serr_q    <= serr_d;
      sdata_q   <= sdata_d;
    end
  end

endmodule

// File: tb/tb_brq_tlul_host_arb.sv
// Bench for brq_tlul_host_arb: directed scenarios plus random traffic, all cycles checked
// against a transaction-list reference model.
module tb_brq_tlul_host_arb;
  import tlul_pkg::*;

  localparam int unsigned NumCh   = 2;
  localparam int unsigned MaxReqs = 2;
  localparam int          SlotW   = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NumCh-1:0]       req_i, gnt_o, we_i, valid_o, err_o;
  logic [NumCh-1:0][31:0] addr_i, wdata_i, rdata_o;
  logic [NumCh-1:0][3:0]  be_i;
  tl_h2d_t                tl_h_o;
  tl_d2h_t                tl_h_i;

  always #5 clk_i = ~clk_i;

  brq_tlul_host_arb #(
    .NumCh  (NumCh),
    .MaxReqs(MaxReqs)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .gnt_o  (gnt_o),
    .addr_i (addr_i),
    .we_i   (we_i),
    .wdata_i(wdata_i),
    .be_i   (be_i),
    .valid_o(valid_o),
    .rdata_o(rdata_o),
    .err_o  (err_o),
    .tl_h_o (tl_h_o),
    .tl_h_i (tl_h_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: per channel, an in-order list of outstanding transactions.
  int          m_n    [NumCh];
  int          m_iss  [NumCh];
  int          m_slot [NumCh][MaxReqs];
  bit          m_done [NumCh][MaxReqs];
  logic [31:0] m_data [NumCh][MaxReqs];
  bit          m_err  [NumCh][MaxReqs];
  int          m_rr;
  bit          m_lock;
  int          m_lock_ch;

  task automatic model_reset();
    for (int c = 0; c < NumCh; c++) begin
      m_n[c]   = 0;
      m_iss[c] = 0;
    end
    m_rr      = 0;
    m_lock    = 0;
    m_lock_ch = 0;
  endtask

  function automatic bit is_pending(input int src);
    int ch;
    int sl;
    ch = src >> SlotW;
    sl = src % (1 << SlotW);
    if (ch >= NumCh) return 0;
    for (int k = 0; k < m_n[ch]; k++) if (m_slot[ch][k] == sl) return 1;
    return 0;
  endfunction

  task automatic model_step();
    bit        ret [NumCh];
    bit        d_used;
    bit        av;
    bit        found;
    int        d_ch, d_slot, win, idx;
    logic [7:0] exp_src;
    tl_a_op_e  exp_op;
    logic [NumCh-1:0] exp_gnt;
    d_ch   = int'(tl_h_i.d_source) >> SlotW;
    d_slot = int'(tl_h_i.d_source) % (1 << SlotW);
    d_used = 0;
    for (int c = 0; c < NumCh; c++) begin
      ret[c] = 0;
      if (m_n[c] > 0 && m_done[c][0]) begin
        ret[c] = 1;
        check_eq($sformatf("valid[%0d]", c), valid_o[c], 1'b1);
        check_eq($sformatf("rdata[%0d]", c), rdata_o[c], m_data[c][0]);
        check_eq($sformatf("err[%0d]", c), err_o[c], m_err[c][0]);
      end
`ifdef BRQ_TLUL_RSP_BYPASS_EN
      else if (tl_h_i.d_valid && d_ch == c && m_n[c] > 0 && m_slot[c][0] == d_slot) begin
        ret[c] = 1;
        d_used = 1;
        check_eq($sformatf("byp_valid[%0d]", c), valid_o[c], 1'b1);
        check_eq($sformatf("byp_rdata[%0d]", c), rdata_o[c], tl_h_i.d_data);
        check_eq($sformatf("byp_err[%0d]", c), err_o[c], tl_h_i.d_error);
      end
`endif
      else begin
        check_eq($sformatf("idle_valid[%0d]", c), valid_o[c], 1'b0);
      end
    end
    av  = 0;
    win = 0;
    if (m_lock) begin
      av  = 1;
      win = m_lock_ch;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        idx = (m_rr + i) % NumCh;
        if (!av && req_i[idx] && m_n[idx] < int'(MaxReqs)) begin
          av  = 1;
          win = idx;
        end
      end
    end
    check_eq("a_valid", tl_h_o.a_valid, av);
    check_eq("d_ready", tl_h_o.d_ready, 1'b1);
    exp_gnt = '0;
    if (av && tl_h_i.a_ready) exp_gnt[win] = 1'b1;
    check_eq("gnt", gnt_o, exp_gnt);
    if (av) begin
      exp_src = 8'(win * (1 << SlotW) + m_iss[win] % int'(MaxReqs));
      exp_op  = !we_i[win] ? Get : ((be_i[win] == 4'hF) ? PutFullData : PutPartialData);
      check_eq("a_source", tl_h_o.a_source, exp_src);
      check_eq("a_address", tl_h_o.a_address, {addr_i[win][31:2], 2'b00});
      check_eq("a_opcode", tl_h_o.a_opcode, exp_op);
      check_eq("a_mask", tl_h_o.a_mask, be_i[win]);
      check_eq("a_data", tl_h_o.a_data, wdata_i[win]);
      check_eq("a_size", tl_h_o.a_size, 2'd2);
    end
    // Response capture: first outstanding, not-yet-answered entry with that slot.
    if (tl_h_i.d_valid && !d_used && d_ch < NumCh) begin
      found = 0;
      for (int k = 0; k < m_n[d_ch]; k++) begin
        if (!found && m_slot[d_ch][k] == d_slot && !m_done[d_ch][k]) begin
          found             = 1;
          m_done[d_ch][k]   = 1;
          m_data[d_ch][k]   = tl_h_i.d_data;
          m_err[d_ch][k]    = tl_h_i.d_error;
        end
      end
    end
    for (int c = 0; c < NumCh; c++) begin
      if (ret[c]) begin
        for (int k = 0; k < MaxReqs - 1; k++) begin
          m_slot[c][k] = m_slot[c][k+1];
          m_done[c][k] = m_done[c][k+1];
          m_data[c][k] = m_data[c][k+1];
          m_err[c][k]  = m_err[c][k+1];
        end
        m_n[c]--;
      end
    end
    if (av && tl_h_i.a_ready) begin
      m_slot[win][m_n[win]] = m_iss[win] % int'(MaxReqs);
      m_done[win][m_n[win]] = 0;
      m_n[win]++;
      m_iss[win]++;
      m_rr = (win + 1) % NumCh;
    end
    m_lock    = av && !tl_h_i.a_ready;
    m_lock_ch = win;
  endtask

  // Every cycle: reset values while in reset, otherwise the full model comparison.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check_eq("rst_a_valid", tl_h_o.a_valid, 1'b0);
      check_eq("rst_d_ready", tl_h_o.d_ready, 1'b1);
      check_eq("rst_gnt", gnt_o, '0);
      check_eq("rst_valid", valid_o, '0);
      check_eq("rst_rdata", rdata_o, '0);
      check_eq("rst_err", err_o, '0);
      model_reset();
    end else begin
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req_i          = '0;
    tl_h_i.d_valid = 1'b0;
    rst_ni         = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic d_set(input logic [7:0] src, input logic [31:0] data, input logic err);
    tl_h_i.d_valid  = 1'b1;
    tl_h_i.d_opcode = AccessAckData;
    tl_h_i.d_source = src;
    tl_h_i.d_data   = data;
    tl_h_i.d_error  = err;
  endtask

  task automatic set_req(input int c, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd);
    req_i[c]   = 1'b1;
    addr_i[c]  = a;
    we_i[c]    = w;
    be_i[c]    = b;
    wdata_i[c] = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0]      got_d[$];
  int               got_k[$];
  logic [7:0]       dev_q[$];
  logic [NumCh-1:0] g;
  int               seen;
  int               r;

  initial begin
    rst_ni  = 1'b0;
    req_i   = '0;
    addr_i  = '0;
    we_i    = '0;
    wdata_i = '0;
    be_i    = '0;
    tl_h_i  = '0;
    model_reset();
    tick();
    tick();
    rst_ni          = 1'b1;
    tl_h_i.a_ready  = 1'b1;

    // Single read, answered three cycles after issue.
    set_req(0, 32'h1000_0006, 1'b0, 4'hF, 32'h0);
    @(negedge clk_i);
    check_eq("t1_opcode", tl_h_o.a_opcode, Get);
    check_eq("t1_address", tl_h_o.a_address, 32'h1000_0004);
    check_eq("t1_source", tl_h_o.a_source, 8'h00);
    check_eq("t1_mask", tl_h_o.a_mask, 4'hF);
    check_eq("t1_gnt", gnt_o, 2'b01);
    tick();
    req_i[0] = 1'b0;
    tick();
    tick();
    d_set(8'h00, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk_i);
`ifdef BRQ_TLUL_RSP_BYPASS_EN
    check_eq("t1_valid_same", valid_o[0], 1'b1);
    check_eq("t1_rdata_same", rdata_o[0], 32'hDEAD_BEEF);
`else
    check_eq("t1_valid_same", valid_o[0], 1'b0);
`endif
    tick();
    tl_h_i.d_valid = 1'b0;
    @(negedge clk_i);
`ifdef BRQ_TLUL_RSP_BYPASS_EN
    check_eq("t1_valid_next", valid_o[0], 1'b0);
`else
    check_eq("t1_valid_next", valid_o[0], 1'b1);
    check_eq("t1_rdata_next", rdata_o[0], 32'hDEAD_BEEF);
`endif
    tick();

    // Simultaneous requests, then ch1 out-of-order responses.
    do_reset();
    set_req(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    set_req(1, 32'h0000_0200, 1'b0, 4'hF, 32'h0);
    @(negedge clk_i);
    check_eq("t2_gnt0", gnt_o, 2'b01);
    check_eq("t2_src0", tl_h_o.a_source, 8'h00);
    tick();
    req_i[0] = 1'b0;
    @(negedge clk_i);
    check_eq("t2_gnt1", gnt_o, 2'b10);
    check_eq("t2_src1", tl_h_o.a_source, 8'h02);
    tick();
    addr_i[1] = 32'h0000_0204;
    @(negedge clk_i);
    check_eq("t3_src_slot1", tl_h_o.a_source, 8'h03);
    tick();
    req_i[1] = 1'b0;
    d_set(8'h03, 32'hBBBB_0002, 1'b0);
    tick();
    d_set(8'h02, 32'hAAAA_0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (valid_o[1]) begin
        got_d.push_back(rdata_o[1]);
        got_k.push_back(k);
      end
      tick();
      if (k == 0) d_set(8'h00, 32'h1234_5678, 1'b0);
      if (k == 1) tl_h_i.d_valid = 1'b0;
    end
    check_eq("t3_count", got_d.size(), 2);
    if (got_d.size() == 2) begin
      check_eq("t3_first", got_d[0], 32'hAAAA_0001);
      check_eq("t3_second", got_d[1], 32'hBBBB_0002);
      check_eq("t3_spacing", got_k[1] - got_k[0], 1);
    end

    // Outstanding limit on ch0.
    do_reset();
    set_req(0, 32'h0000_3000, 1'b0, 4'hF, 32'h0);
    @(negedge clk_i);
    check_eq("t4_gnt_a", gnt_o, 2'b01);
    tick();
    addr_i[0] = 32'h0000_3004;
    @(negedge clk_i);
    check_eq("t4_gnt_b", gnt_o, 2'b01);
    tick();
    addr_i[0] = 32'h0000_3008;
    @(negedge clk_i);
    check_eq("t4_blocked_valid", tl_h_o.a_valid, 1'b0);
    check_eq("t4_blocked_gnt", gnt_o, 2'b00);
    tick();
    d_set(8'h00, 32'h0000_0AAA, 1'b0);
    seen = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (valid_o[0] && seen < 0) begin
        seen = k;
        check_eq("t4_gnt_at_retire", gnt_o[0], 1'b0);
      end else if (seen >= 0 && k == seen + 1) begin
        check_eq("t4_gnt_after_retire", gnt_o[0], 1'b1);
        check_eq("t4_src_reuse", tl_h_o.a_source, 8'h00);
      end
      tick();
      if (k == 0) tl_h_i.d_valid = 1'b0;
      if (seen >= 0 && k == seen + 1) req_i[0] = 1'b0;
    end
    check_eq("t4_retired", seen >= 0, 1'b1);

    // Partial write answered with an error.
    do_reset();
    set_req(0, 32'h0000_4000, 1'b1, 4'h3, 32'hCAFE_F00D);
    @(negedge clk_i);
    check_eq("t5_opcode", tl_h_o.a_opcode, PutPartialData);
    check_eq("t5_mask", tl_h_o.a_mask, 4'h3);
    tick();
    req_i[0] = 1'b0;
    d_set(8'h00, 32'h0, 1'b1);
    seen = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (valid_o[0] && seen < 0) begin
        seen = k;
        check_eq("t5_err", err_o[0], 1'b1);
      end
      tick();
      tl_h_i.d_valid = 1'b0;
    end
    check_eq("t5_responded", seen >= 0, 1'b1);

    // Stall lock: ch0 issues once so rr points at ch1, then ch0 stalls while ch1 requests.
    do_reset();
    set_req(0, 32'h0000_5000, 1'b0, 4'hF, 32'h0);
    tick();
    addr_i[0]      = 32'h2000_0010;
    tl_h_i.a_ready = 1'b0;
    @(negedge clk_i);
    check_eq("t6_valid_first", tl_h_o.a_valid, 1'b1);
    tick();
    set_req(1, 32'h0000_6000, 1'b0, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check_eq("t6_lock_addr", tl_h_o.a_address, 32'h2000_0010);
      check_eq("t6_lock_src", tl_h_o.a_source, 8'h01);
      check_eq("t6_lock_gnt", gnt_o, 2'b00);
      tick();
    end
    tl_h_i.a_ready = 1'b1;
    @(negedge clk_i);
    check_eq("t6_gnt_ch0", gnt_o, 2'b01);
    tick();
    req_i[0] = 1'b0;
    @(negedge clk_i);
    check_eq("t6_gnt_ch1", gnt_o, 2'b10);
    tick();
    do_reset();
    d_set(8'h01, 32'h5555_5555, 1'b0);
    tick();
    d_set(8'h02, 32'h6666_6666, 1'b0);
    tick();
    tl_h_i.d_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check_eq("t6_late_dropped", valid_o, 2'b00);
      tick();
    end

    // Random traffic with out-of-order device responses and one mid-run reset.
    do_reset();
    dev_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      g = gnt_o;
      if (tl_h_o.a_valid && tl_h_i.a_ready) dev_q.push_back(tl_h_o.a_source);
      tick();
      for (int c = 0; c < NumCh; c++) begin
        if ((req_i[c] && g[c]) || (!req_i[c] && $urandom_range(0, 2) == 0)) begin
          if ($urandom_range(0, 1) == 1)
            set_req(c, $urandom, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom), $urandom);
          else
            req_i[c] = 1'b0;
        end
      end
      tl_h_i.a_ready = ($urandom_range(0, 3) != 0);
      tl_h_i.d_valid = 1'b0;
      if (dev_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, dev_q.size() - 1);
        d_set(dev_q[r], $urandom, 1'($urandom_range(0, 7) == 0));
        dev_q.delete(r);
      end else if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 255);
        if (!is_pending(r)) d_set(8'(r), $urandom, 1'b0);
      end
      if (cyc == 1500) begin
        do_reset();
        dev_q.delete();
      end
    end
    req_i          = '0;
    tl_h_i.d_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/brq_tlul_host_arb.md
# brq_tlul_host_arb

Multi-channel TL-UL host adapter for the brq core complex. Merges `NumCh` independent core-side req/gnt/rvalid ports (instruction fetch, data LSU, debug/DMA masters) onto one TL-UL host port with round-robin arbitration. Each channel can have up to `MaxReqs` transactions in flight, and every in-flight transaction carries a unique source ID. Responses may return out of order across sources; per-channel reorder storage delivers them to each channel in issue order. It replaces the per-port single-channel adapters in the core top.

## Interface
Parameters:
- `NumCh`, 2, number of core-side channels (1..8)
- `MaxReqs`, 2, outstanding transactions per channel (1..8). Constraint: `ChW + SlotW <= 8`, where `ChW = max(1,$clog2(NumCh))` and `SlotW = max(1,$clog2(MaxReqs))`.

Ports:
- `clk_i` in 1 clock
- `rst_ni` in 1 reset, asynchronous, active-low
- `req_i` in [NumCh] request per channel
- `gnt_o` out [NumCh] request accepted
- `addr_i` in [NumCh][32] byte address
- `we_i` in [NumCh] write enable
- `wdata_i` in [NumCh][32] write data
- `be_i` in [NumCh][4] byte enables
- `valid_o` out [NumCh] response valid, one-cycle pulse
- `rdata_o` out [NumCh][32] response data
- `err_o` out [NumCh] response error, qualified by `valid_o`
- `tl_h_o` out tlul_pkg::tl_h2d_t TL-UL A channel and `d_ready`
- `tl_h_i` in tlul_pkg::tl_d2h_t TL-UL D channel and `a_ready`

## Operation
- **Eligibility:** channel c is eligible when `req_i[c]` is high and `cnt[c] < MaxReqs`.
- **Arbitration:** round-robin. Pointer `rr` (reset 0) selects the first eligible channel at or after `rr`.
- **Pointer advance:** on an A handshake (`a_valid && a_ready`), `rr` becomes winner+1, wrapping to 0 after `NumCh-1`.
- **Lock:** if `a_valid` is high and `a_ready` is low, the winner is registered and held until the handshake. A_valid, address, data and source stay stable regardless of other channels' requests.
- **A-channel fields:**
  - `a_address = {addr[31:2],2'b00}`, `a_size = 2`, `a_mask = be`, `a_param = 0`, `a_user` = default.
  - `a_opcode`: Get if `!we`; PutFullData if `we && be==4'hF`; PutPartialData otherwise.
- **Grant:** `gnt_o[c] = a_ready && a_valid && winner==c`. The core holds req and payload until gnt.
- **Source ID:** `a_source = {c, iptr[c]}`, zero-extended to 8 bits. `iptr[c]` is the per-channel issue pointer, modulo `MaxReqs`, and increments on handshake.
- **Reorder storage:** per-channel slot table with `pend`, `done`, `data` and `err` per slot.
  - A handshake sets `pend[c][iptr]`.
  - A D beat (`d_ready` is tied to 1) with `d_source = {c,s}` and `pend[c][s]` set stores `d_data` and `d_error`, and sets `done`.
- **Retire:**
  - When `done[c][rptr[c]]` is set, assert `valid_o[c]`, `rdata_o[c]` and `err_o[c]` for one cycle.
  - Then clear `pend` and `done` for that slot and increment `rptr[c]`.
  - At most one retire per channel per cycle.
- **Outstanding count:** `cnt[c]` increments on handshake and decrements on retire. A handshake and a retire in the same cycle leave it unchanged.
- **Unexpected D beat:** a D beat whose channel is `>= NumCh` or whose slot is not pending is accepted and discarded. No state changes.
- **Reset (including mid-operation):** clears all slots, pointers, counts, the lock and `rr`. D responses for pre-reset requests are then unexpected and discarded.

## Timing
- **Reset values:** `gnt_o=0`, `valid_o=0`, `rdata_o=0`, `err_o=0`, `a_valid=0`, `d_ready=1`.
- **Grant path:** `a_valid` and `gnt_o` are combinational from `req_i`, `cnt` and `a_ready`. No added request latency.
- **Response latency:** a D beat in cycle N for the head slot produces `valid_o` in cycle N+1 (registered outputs).
- **Later slots:** an out-of-order slot retires in the cycle after the head slot retires.
- **Back-to-back issue:** one A handshake per cycle maximum. A channel may issue in consecutive cycles until `cnt == MaxReqs`.

## Configuration
- **`BRQ_TLUL_RSP_BYPASS_EN` defined:** a D beat that targets the head slot `rptr[c]` while that slot is not done is forwarded combinationally. `valid_o`, `rdata_o` and `err_o` assert in cycle N, and the slot is not stored.
  - Retire and `cnt` update as for a normal retire.
  - Registered retire has priority; it cannot conflict, because the head slot is not done.
- **Undefined:** all responses are registered, with N+1 latency.

## Test plan
- **Single read:** ch0 read of `0x1000_0006`, device answers `0xDEADBEEF` 3 cycles later.
  - A channel: `a_opcode=Get`, `a_address=0x1000_0004`, `a_source=0x00`, `a_mask=0xF`.
  - Response: `valid_o[0]` one cycle after `d_valid` (same cycle with the bypass macro), `rdata_o[0]=0xDEADBEEF`.
- **Simultaneous requests:** ch0 and ch1 request in the same cycle with `rr=0`.
  - ch0 is granted first with `a_source=0x00`.
  - ch1 is granted the next cycle with `a_source=0x02`.
- **Out-of-order responses:** ch1 issues slot0 then slot1. The device returns source `0x03` with data B, then `0x02` with data A. `valid_o[1]` must pulse with A, then with B on the following cycle.
- **Outstanding limit:** ch0 makes three back-to-back reads with no responses and `MaxReqs=2`.
  - The third read is not granted and `a_valid` stays low.
  - It is granted in the cycle after the first retire.
- **Partial write with error:** write with `be=0x3`, device responds with `d_error=1`.
  - A channel: `a_opcode=PutPartialData`, `a_mask=0x3`.
  - Response: `err_o` pulses together with `valid_o`.
- **Stall lock, then reset:** hold `a_ready` low for 4 cycles while ch1 raises `req_i`.
  - The ch0 address and source stay stable and ch0 is granted first.
  - Asserting `rst_ni` low mid-flight clears all pending slots; the late D beat is dropped with no `valid_o`.
